lpm_add_sub_pipe: RTL

//  Parametrised adder/subtractor for the Lava simulation library: dynamic add/sub, honoured pipeline

---
 rtl/lpm_pkg.sv | 19 +
 rtl/lpm_add_seg.sv | 22 ++
 rtl/lpm_add_sub_pipe.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/lpm_pkg.sv
// lpm_pkg: shared constants and helpers for the LPM arithmetic primitives.
package lpm_pkg;

   localparam int DIR_ADD      = 0;
   localparam int DIR_SUB      = 1;
   localparam int DIR_DYNAMIC  = 2;
   localparam int REP_UNSIGNED = 0;
   localparam int REP_SIGNED   = 1;

   function automatic int seg_width(input int width, input int n);
      return (width + n - 1) / n;
   endfunction

   // Unsigned add overflows on carry-out; unsigned subtract overflows on borrow.
   function automatic logic ovf_rule(input int rep, input logic add, input logic co, input logic cm);
      return (rep == REP_SIGNED) ? (cm ^ co) : (add ? co : ~co);
   endfunction

endpackage

// File: rtl/lpm_add_seg.sv
// lpm_add_seg: SEG-bit adder slice with optional operand-B inversion,
// exposing both the carry-out and the carry into its own MSB.
module lpm_add_seg #(
   parameter int SEG = 8
) (
   input  logic [SEG-1:0] a,
   input  logic [SEG-1:0] b,
   input  logic           ci,
   input  logic           inv_b,
   output logic [SEG-1:0] s,
   output logic           co,
   output logic           cm
);

   logic [SEG-1:0] bo;

   assign bo      = inv_b ? ~b : b;
   assign {co, s} = {1'b0, a} + {1'b0, bo} + {{SEG{1'b0}}, ci};
   // The MSB sum bit is a^b^carry_in, so the incoming carry falls out of it.
   assign cm      = s[SEG-1] ^ a[SEG-1] ^ bo[SEG-1];

endmodule

// File: rtl/lpm_add_sub_pipe.sv
// lpm_add_sub_pipe: adder/subtractor with the carry chain split across
// PIPELINE stages, clken stall and valid tagging.
module lpm_add_sub_pipe
   import lpm_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int PIPELINE   = 0,
   parameter int SIGNED_REP = 0,
   parameter int DIRECTION  = 2
) (
   input  logic             clock,
   input  logic             aclr_n,
   input  logic             clken,
   input  logic             in_valid,
   input  logic             add_sub,
   input  logic             cin,
   input  logic [WIDTH-1:0] dataa,
   input  logic [WIDTH-1:0] datab,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             overflow,
   output logic             out_valid
);

   logic as_in;

   assign as_in = (DIRECTION == DIR_ADD) ? 1'b1 : (DIRECTION == DIR_SUB) ? 1'b0 : add_sub;

   generate
      if (WIDTH < 1 || PIPELINE < 0 || PIPELINE > WIDTH) begin : g_bad
         $error("lpm_add_sub_pipe: need WIDTH>=1 and 0<=PIPELINE<=WIDTH");
      end

      if (PIPELINE == 0) begin : g_comb
         logic cm;
         logic unused_ok;
         assign unused_ok = ^{clock, aclr_n, clken};
         lpm_add_seg #(.SEG(WIDTH)) u_seg (
            .a     (dataa),
            .b     (datab),
            .ci    (cin),
            .inv_b (~as_in),
            .s     (result),
            .co    (cout),
            .cm    (cm)
         );
         assign overflow  = ovf_rule(SIGNED_REP, as_in, cout, cm);
         assign out_valid = in_valid;
      end else begin : g_pipe
         localparam int SEG = seg_width(WIDTH, PIPELINE);
         // *_d: stage inputs, *_n: stage results, *_q: stage registers
         logic [WIDTH-1:0] a_d [PIPELINE];
         logic [WIDTH-1:0] b_d [PIPELINE];
         logic [WIDTH-1:0] r_d [PIPELINE];
         logic             as_d [PIPELINE];
         logic             c_d [PIPELINE];
         logic             ov_d [PIPELINE];
         logic             v_d [PIPELINE];
         logic [WIDTH-1:0] r_n [PIPELINE];
         logic             c_n [PIPELINE];
         logic             cm_n [PIPELINE];
         logic             ov_n [PIPELINE];
         logic [WIDTH-1:0] a_q [PIPELINE];
         logic [WIDTH-1:0] b_q [PIPELINE];
         logic [WIDTH-1:0] r_q [PIPELINE];
         logic             as_q [PIPELINE];
         logic             c_q [PIPELINE];
         logic             ov_q [PIPELINE];
         logic             v_q [PIPELINE];

         for (genvar k = 0; k < PIPELINE; k++) begin : g_stg
            localparam int LO = (k * SEG < WIDTH) ? k * SEG : WIDTH;
            localparam int HI = ((k + 1) * SEG < WIDTH) ? (k + 1) * SEG : WIDTH;
            localparam int W  = HI - LO;

            if (k == 0) begin : g_in
               assign a_d[k]  = dataa;
               assign b_d[k]  = datab;
               assign r_d[k]  = '0;
               assign as_d[k] = as_in;
               assign c_d[k]  = cin;
               assign ov_d[k] = 1'b0;
               assign v_d[k]  = in_valid;
            end else begin : g_chain
               assign a_d[k]  = a_q[k-1];
               assign b_d[k]  = b_q[k-1];
               assign r_d[k]  = r_q[k-1];
               assign as_d[k] = as_q[k-1];
               assign c_d[k]  = c_q[k-1];
               assign ov_d[k] = ov_q[k-1];
               assign v_d[k]  = v_q[k-1];
            end

            // Ceil-sized segments can run out before the last stage; those stages only delay.
            if (W > 0) begin : g_add
               logic [W-1:0] s;
               lpm_add_seg #(.SEG(W)) u_seg (
                  .a     (a_d[k][LO +: W]),
                  .b     (b_d[k][LO +: W]),
                  .ci    (c_d[k]),
                  .inv_b (~as_d[k]),
                  .s     (s),
                  .co    (c_n[k]),
                  .cm    (cm_n[k])
               );
               assign r_n[k]  = r_d[k] | (WIDTH'(s) << LO);
               assign ov_n[k] = (HI == WIDTH) ? ovf_rule(SIGNED_REP, as_d[k], c_n[k], cm_n[k]) : ov_d[k];
            end else begin : g_pass
               assign r_n[k]  = r_d[k];
               assign c_n[k]  = c_d[k];
               assign cm_n[k] = 1'b0;
               assign ov_n[k] = ov_d[k];
            end

            always_ff @(posedge clock or negedge aclr_n) begin
               if (!aclr_n) begin
                  a_q[k]  <= '0;
                  b_q[k]  <= '0;
                  r_q[k]  <= '0;
                  as_q[k] <= 1'b0;
                  c_q[k]  <= 1'b0;
                  ov_q[k] <= 1'b0;
                  v_q[k]  <= 1'b0;
               end else if (clken) begin
                  a_q[k]  <= a_d[k];
                  b_q[k]  <= b_d[k];
                  r_q[k]  <= r_n[k];
                  as_q[k] <= as_d[k];
                  c_q[k]  <= c_n[k];
                  ov_q[k] <= ov_n[k];
                  v_q[k]  <= v_d[k];
               end
            end
         end

         assign result    = r_q[PIPELINE-1];
         assign cout      = c_q[PIPELINE-1];
         assign overflow  = ov_q[PIPELINE-1];
         assign out_valid = v_q[PIPELINE-1];
      end
   endgenerate

endmodule
